// File: rtl/pixel_frame_streamer_pkg.sv
// Shared definitions for the pixel frame streamer and the Gaussian window buffer it feeds.
package pixel_frame_streamer_pkg;

  localparam int DEF_WIDTH  = 512;
  localparam int DEF_HEIGHT = 512;
  localparam int R_KERNEL   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_GAP,
    ST_FLUSH,
    ST_DONE
  } state_e;

  function automatic logic is_busy_state(input state_e s);
    return (s == ST_READ) || (s == ST_GAP) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/pixel_frame_streamer_raster_counter.sv
// Column/row raster counter with end-of-row and end-of-frame flags; clear has priority over enable.
module raster_counter
  import pixel_frame_streamer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int COORD_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               eol,
  output logic               eof
);

  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;

  assign eol = (col_q == COORD_W'(WIDTH - 1));
  assign eof = eol && (row_q == COORD_W'(HEIGHT - 1));
  assign col = col_q;
  assign row = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (eol) begin
        col_d = '0;
        row_d = eof ? '0 : row_q + COORD_W'(1);
      end else begin
        col_d = col_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/pixel_frame_streamer.sv
// Reads a WIDTH x HEIGHT frame from a 1-cycle-latency RAM and streams it in raster order,
// one pixel per cycle with optional blanking between rows; the pixel stream trails the reads by one cycle.
module pixel_frame_streamer
  import pixel_frame_streamer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int LINE_GAP = 0,
  parameter int ADDR_W   = 18,
  parameter int COORD_W  = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [7:0]         mem_rd_data,
  output logic               pix_write,
  output logic [7:0]         pix_data,
  output logic [COORD_W-1:0] pix_col,
  output logic [COORD_W-1:0] pix_row,
  output logic               busy,
  output logic               frame_done
);

  localparam int GAP_W    = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int GAP_LAST = (LINE_GAP > 0) ? LINE_GAP - 1 : 0;

  state_e             state_q, state_d;
  logic               rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pix_write_q, pix_write_d;
  logic [COORD_W-1:0] pix_col_q, pix_col_d;
  logic [COORD_W-1:0] pix_row_q, pix_row_d;
  logic [7:0]         pix_hold_q, pix_hold_d;

  logic               rc_clear, rc_en, rc_eol, rc_eof;
  logic [COORD_W-1:0] rc_col, rc_row;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .COORD_W(COORD_W)
  ) u_rd_raster (
    .clk  (clk),
    .rst  (rst),
    .clear(rc_clear),
    .en   (rc_en),
    .col  (rc_col),
    .row  (rc_row),
    .eol  (rc_eol),
    .eof  (rc_eof)
  );

  // The raster counter always names the read currently on mem_addr; it advances on the cycle
  // that read is issued, so it already points at the next row's first pixel during blanking.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    gap_cnt_d = gap_cnt_q;
    rc_clear  = 1'b0;
    rc_en     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_READ;
          rd_en_d  = 1'b1;
          addr_d   = '0;
          rc_clear = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rc_eof) begin
          state_d = ST_FLUSH;
        end else begin
          rc_en  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          if (rc_eol && (LINE_GAP > 0)) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else begin
            rd_en_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = is_busy_state(state_d);
    done_d = (state_d == ST_DONE);

    pix_write_d = rd_en_q;
    pix_col_d   = rd_en_q ? rc_col : pix_col_q;
    pix_row_d   = rd_en_q ? rc_row : pix_row_q;
    pix_hold_d  = pix_write_q ? mem_rd_data : pix_hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      gap_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_write_q <= 1'b0;
      pix_col_q   <= '0;
      pix_row_q   <= '0;
      pix_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      gap_cnt_q   <= gap_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_write_q <= pix_write_d;
      pix_col_q   <= pix_col_d;
      pix_row_q   <= pix_row_d;
      pix_hold_q  <= pix_hold_d;
    end
  end

  // RAM output is already a register; pass it straight through on write cycles, hold otherwise.
  assign pix_data   = pix_write_q ? mem_rd_data : pix_hold_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign pix_write  = pix_write_q;
  assign pix_col    = pix_col_q;
  assign pix_row    = pix_row_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Directed bench: 8x4 frames with no blanking (dut a) and 3-cycle blanking (dut b).
module tb_pixel_frame_streamer;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 18;
  localparam int CW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, ff_mode, sel;

  logic          a_rd_en, b_rd_en, a_pw, b_pw, a_busy, b_busy, a_done, b_done;
  logic [AW-1:0] a_addr, b_addr;
  logic [7:0]    a_rdata, b_rdata, a_pd, b_pd;
  logic [CW-1:0] a_col, a_row, b_col, b_row;

  pixel_frame_streamer #(.WIDTH(W), .HEIGHT(H), .LINE_GAP(0), .ADDR_W(AW), .COORD_W(CW)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mem_rd_en(a_rd_en), .mem_addr(a_addr),
    .mem_rd_data(a_rdata), .pix_write(a_pw), .pix_data(a_pd), .pix_col(a_col),
    .pix_row(a_row), .busy(a_busy), .frame_done(a_done));

  pixel_frame_streamer #(.WIDTH(W), .HEIGHT(H), .LINE_GAP(3), .ADDR_W(AW), .COORD_W(CW)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mem_rd_en(b_rd_en), .mem_addr(b_addr),
    .mem_rd_data(b_rdata), .pix_write(b_pw), .pix_data(b_pd), .pix_col(b_col),
    .pix_row(b_row), .busy(b_busy), .frame_done(b_done));

  // Image RAM models: mem[i] = i & 8'hFF, or all 8'hFF in ff_mode.
  always @(posedge clk) if (a_rd_en) a_rdata <= ff_mode ? 8'hFF : a_addr[7:0];
  always @(posedge clk) if (b_rd_en) b_rdata <= ff_mode ? 8'hFF : b_addr[7:0];

  logic          s_rd_en, s_pw, s_busy, s_done;
  logic [AW-1:0] s_addr;
  logic [7:0]    s_pd;
  logic [CW-1:0] s_col, s_row;

  always_comb begin
    s_rd_en = sel ? b_rd_en : a_rd_en;
    s_addr  = sel ? b_addr  : a_addr;
    s_pw    = sel ? b_pw    : a_pw;
    s_pd    = sel ? b_pd    : a_pd;
    s_col   = sel ? b_col   : a_col;
    s_row   = sel ? b_row   : a_row;
    s_busy  = sel ? b_busy  : a_busy;
    s_done  = sel ? b_done  : a_done;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_en"}, 32'(s_rd_en), 0);
    check({tag, " addr"},  32'(s_addr),  0);
    check({tag, " pw"},    32'(s_pw),    0);
    check({tag, " pd"},    32'(s_pd),    0);
    check({tag, " col"},   32'(s_col),   0);
    check({tag, " row"},   32'(s_row),   0);
    check({tag, " busy"},  32'(s_busy),  0);
    check({tag, " done"},  32'(s_done),  0);
  endtask

  // Start sampled at cycle 0; called at a negedge, each loop iteration checks cycle c.
  task automatic run_frame(input int g, input bit pulses, input int ncyc);
    int per, t, r, cc, last_wr, ld, lc, lr;
    bit exp_pw, exp_rd;
    per     = W + g;
    last_wr = 2 + (H - 1) * per + (W - 1);
    ld = 0; lc = 0; lr = 0;
    sel   = (g != 0);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      t = c - 2; exp_pw = 1'b0; r = 0; cc = 0;
      if (t >= 0) begin
        r = t / per; cc = t % per;
        exp_pw = (r < H) && (cc < W);
      end
      check($sformatf("g%0d pix_write c%0d", g, c), 32'(s_pw), 32'(exp_pw));
      if (exp_pw) begin
        ld = ff_mode ? 8'hFF : ((r * W + cc) & 8'hFF);
        lc = cc; lr = r;
      end
      if (c >= 2) begin
        check($sformatf("g%0d pix_data c%0d", g, c), 32'(s_pd),  32'(ld));
        check($sformatf("g%0d pix_col c%0d", g, c),  32'(s_col), 32'(lc));
        check($sformatf("g%0d pix_row c%0d", g, c),  32'(s_row), 32'(lr));
      end
      t = c - 1; exp_rd = 1'b0;
      if (t >= 0) begin
        r = t / per; cc = t % per;
        exp_rd = (r < H) && (cc < W);
      end
      check($sformatf("g%0d rd_en c%0d", g, c), 32'(s_rd_en), 32'(exp_rd));
      if (exp_rd) check($sformatf("g%0d addr c%0d", g, c), 32'(s_addr), 32'(r * W + cc));
      check($sformatf("g%0d busy c%0d", g, c), 32'(s_busy), 32'(c <= last_wr));
      check($sformatf("g%0d frame_done c%0d", g, c), 32'(s_done), 32'(c == last_wr + 1));
      start = pulses && (c == 5 || c == 10);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ff_mode = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset a");
    sel = 1'b1;
    check_all_zero("reset b");
    rst = 1'b0;

    // Frame with stray start pulses at cycles 5 and 10, then the blanked frame.
    run_frame(0, 1'b1, 48);
    run_frame(3, 1'b0, 48);

    ff_mode = 1'b1;
    run_frame(0, 1'b0, 40);
    ff_mode = 1'b0;

    // start held high: back-to-back frames.
    sel = 1'b0; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 34) begin
        check("held done c34", 32'(s_done), 1);
        check("held busy c34", 32'(s_busy), 0);
      end
      if (c == 35) begin
        check("held pw c35",    32'(s_pw),    0);
        check("held rd_en c35", 32'(s_rd_en), 1);
        check("held addr c35",  32'(s_addr),  0);
        check("held busy c35",  32'(s_busy),  1);
      end
      if (c == 36) begin
        check("held pw c36",  32'(s_pw),  1);
        check("held pd c36",  32'(s_pd),  0);
        check("held col c36", 32'(s_col), 0);
        check("held row c36", 32'(s_row), 0);
      end
    end
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("post-held reset");

    // Reset while reading row 2, col 3.
    start = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 20) begin
        check("midrst rd_en c20", 32'(s_rd_en), 1);
        check("midrst addr c20",  32'(s_addr),  2 * W + 3);
      end
      if (c == 21) check_all_zero("midrst c21");
      if (c == 22) check_all_zero("midrst c22");
      rst = (c == 20);
    end
    run_frame(0, 1'b0, 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
